// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the CPU control sequencer.
//   OPW         : opcode field width
//   OP_*        : opcode encodings used by the IR and ALU decode
//   state_t     : sequencer state encoding; P0..P7 map to phase 0..7,
//                 HALTED sits outside the phase range
//   is_aluop()  : true for opcodes that read an operand into the accumulator
package cpu_pkg;

   localparam int OPW = 3;

   localparam logic [OPW-1:0] OP_HLT = 3'b000;
   localparam logic [OPW-1:0] OP_SKZ = 3'b001;
   localparam logic [OPW-1:0] OP_ADD = 3'b010;
   localparam logic [OPW-1:0] OP_AND = 3'b011;
   localparam logic [OPW-1:0] OP_XOR = 3'b100;
   localparam logic [OPW-1:0] OP_LDA = 3'b101;
   localparam logic [OPW-1:0] OP_STO = 3'b110;
   localparam logic [OPW-1:0] OP_JMP = 3'b111;

   // Low three bits of the encoding are the debug phase index.
   typedef enum logic [3:0] {
      ST_P0     = 4'd0,
      ST_P1     = 4'd1,
      ST_P2     = 4'd2,
      ST_P3     = 4'd3,
      ST_P4     = 4'd4,
      ST_P5     = 4'd5,
      ST_P6     = 4'd6,
      ST_P7     = 4'd7,
      ST_HALTED = 4'd8
   } state_t;

   function automatic logic is_aluop(input logic [OPW-1:0] op);
      logic res;
      res = 1'b0;
      case (op)
         OP_ADD, OP_AND, OP_XOR, OP_LDA: res = 1'b1;
         default:                        res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/cpu_sequencer_ctrl_decode.sv
// ctrl_decode -- combinational control-strobe decode for the sequencer.
// Inputs : state (current sequencer state), op_q (latched opcode),
//          zero_q (latched accumulator-zero flag), run (phase-advance enable)
// Outputs: sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt
// Strobes with a side effect (wr, ld_ir, ld_ac, inc_pc, ld_pc) are masked
// while run is low so a stalled phase never repeats its action.
module ctrl_decode
   import cpu_pkg::*;
(
   input  state_t         state,
   input  logic [OPW-1:0] op_q,
   input  logic           zero_q,
   input  logic           run,
   output logic           sel,
   output logic           rd,
   output logic           wr,
   output logic           ld_ir,
   output logic           ld_ac,
   output logic           inc_pc,
   output logic           ld_pc,
   output logic           data_e,
   output logic           halt
);

   logic alu_s;
   logic sel_s, rd_s, wr_s, ld_ir_s, ld_ac_s, inc_pc_s, ld_pc_s, data_e_s, halt_s;

   assign alu_s = is_aluop(op_q);

   // Moore decode of raw strobes from state, op_q and zero_q.
   always_comb begin
      sel_s    = 1'b0;
      rd_s     = 1'b0;
      wr_s     = 1'b0;
      ld_ir_s  = 1'b0;
      ld_ac_s  = 1'b0;
      inc_pc_s = 1'b0;
      ld_pc_s  = 1'b0;
      data_e_s = 1'b0;
      halt_s   = 1'b0;
      case (state)
         ST_P0: sel_s = 1'b1;
         ST_P1: begin
            sel_s = 1'b1;
            rd_s  = 1'b1;
         end
         ST_P2: begin
            sel_s   = 1'b1;
            rd_s    = 1'b1;
            ld_ir_s = 1'b1;
         end
         ST_P3: begin
            sel_s = 1'b1;
            rd_s  = 1'b1;
         end
         ST_P4: inc_pc_s = 1'b1;
         ST_P5: rd_s = alu_s;
         ST_P6: begin
            rd_s     = alu_s;
            inc_pc_s = (op_q == OP_SKZ) && zero_q;
            ld_pc_s  = (op_q == OP_JMP);
            data_e_s = (op_q == OP_STO);
         end
         ST_P7: begin
            rd_s     = alu_s;
            ld_ac_s  = alu_s;
            ld_pc_s  = (op_q == OP_JMP);
            wr_s     = (op_q == OP_STO);
            data_e_s = (op_q == OP_STO);
         end
         ST_HALTED: halt_s = 1'b1;
         default: begin
            sel_s = 1'b0;
         end
      endcase
   end

   // Mask side-effecting strobes while the sequencer is stalled.
   always_comb begin
      sel    = sel_s;
      rd     = rd_s;
      data_e = data_e_s;
      halt   = halt_s;
      if (run) begin
         wr     = wr_s;
         ld_ir  = ld_ir_s;
         ld_ac  = ld_ac_s;
         inc_pc = inc_pc_s;
         ld_pc  = ld_pc_s;
      end else begin
         wr     = 1'b0;
         ld_ir  = 1'b0;
         ld_ac  = 1'b0;
         inc_pc = 1'b0;
         ld_pc  = 1'b0;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer -- eight-phase instruction sequencer with halt/resume.
// Parameters: OPW (opcode width, low three bits decoded),
//             HALT_RESUME (1: resume leaves HALTED, 0: HALTED until reset)
// Inputs : clk, rst_n (async active-low), run, resume, opcode, zero
// Outputs: sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, phase
// Holds the state register, the opcode latch (op_q, loaded in P3) and the
// zero-flag latch (zero_q, loaded on P5->P6); strobes come from ctrl_decode.
module cpu_sequencer
   import cpu_pkg::state_t, cpu_pkg::ST_P0, cpu_pkg::ST_P1, cpu_pkg::ST_P2,
          cpu_pkg::ST_P3, cpu_pkg::ST_P4, cpu_pkg::ST_P5, cpu_pkg::ST_P6,
          cpu_pkg::ST_P7, cpu_pkg::ST_HALTED, cpu_pkg::OP_HLT;
#(
   parameter int OPW         = 3,
   parameter bit HALT_RESUME = 1'b1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           run,
   input  logic           resume,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   output logic           sel,
   output logic           rd,
   output logic           wr,
   output logic           ld_ir,
   output logic           ld_ac,
   output logic           inc_pc,
   output logic           ld_pc,
   output logic           data_e,
   output logic           halt,
   output logic [2:0]     phase
);

   state_t         state_r;
   state_t         state_nxt_s;
   logic [OPW-1:0] op_q;
   logic           zero_q;
   logic           armed_r;
   logic           adv_s;

   // The first edge after reset release only arms the sequencer, so the
   // first full P0 cycle follows that edge.
   assign adv_s = run & armed_r;

   // Arm flag: set by the first clock edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_r <= 1'b0;
      end else begin
         armed_r <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_P0;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Opcode latch (leaving P3) and zero-flag latch (leaving P5).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         zero_q <= 1'b0;
      end else begin
         if (adv_s && (state_r == ST_P3)) begin
            op_q <= opcode;
         end
         if (adv_s && (state_r == ST_P5)) begin
            zero_q <= zero;
         end
      end
   end

   // Next-state logic; resume only matters in HALTED.
   always_comb begin
      state_nxt_s = state_r;
      if (adv_s) begin
         case (state_r)
            ST_P0: state_nxt_s = ST_P1;
            ST_P1: state_nxt_s = ST_P2;
            ST_P2: state_nxt_s = ST_P3;
            ST_P3: state_nxt_s = ST_P4;
            ST_P4: begin
               if (op_q[2:0] == OP_HLT) begin
                  state_nxt_s = ST_HALTED;
               end else begin
                  state_nxt_s = ST_P5;
               end
            end
            ST_P5: state_nxt_s = ST_P6;
            ST_P6: state_nxt_s = ST_P7;
            ST_P7: state_nxt_s = ST_P0;
            ST_HALTED: begin
               if (HALT_RESUME && resume) begin
                  state_nxt_s = ST_P0;
               end else begin
                  state_nxt_s = ST_HALTED;
               end
            end
            default: state_nxt_s = ST_P0;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   assign phase = state_r[2:0];

   ctrl_decode u_decode (
      .state  (state_r),
      .op_q   (op_q[2:0]),
      .zero_q (zero_q),
      .run    (run),
      .sel    (sel),
      .rd     (rd),
      .wr     (wr),
      .ld_ir  (ld_ir),
      .ld_ac  (ld_ac),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .data_e (data_e),
      .halt   (halt)
   );

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- OPW, 3, opcode width.
- HALT_RESUME, 1, 1 lets `resume` restart after HLT; 0 leaves HLT terminal until reset.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- run, in, 1, phase-advance enable; when low, state and all registers hold.
- resume, in, 1, single-cycle pulse that leaves the HALTED state.
- opcode, in, OPW, instruction-register opcode field.
- zero, in, 1, accumulator-is-zero flag.
- sel, out, 1, address-mux select: 1 = PC, 0 = IR address field.
- rd, out, 1, memory read strobe.
- wr, out, 1, memory write strobe.
- ld_ir, out, 1, instruction-register load.
- ld_ac, out, 1, accumulator load.
- inc_pc, out, 1, PC increment.
- ld_pc, out, 1, PC load from IR address field.
- data_e, out, 1, accumulator drives the data bus.
- halt, out, 1, CPU halted.
- phase, out, 3, current phase index, for debug.

Function
REQ-003 Opcode encoding SHALL be: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111. ALUOP is the set {ADD, AND, XOR, LDA}.

REQ-004 The FSM states SHALL be P0..P7 plus HALTED.
- P0..P7 advance cyclically by one each cycle while run=1.
- P7 SHALL wrap to P0.

REQ-005 In P3 the block SHALL capture `opcode` into an internal register (op_q). All later decode in the instruction SHALL use op_q.

REQ-006 Outputs SHALL be decoded only from state, op_q and zero_q (Moore style). Outputs not listed for a phase are 0.
- P0: sel.
- P1: sel, rd.
- P2: sel, rd, ld_ir.
- P3: sel, rd.
- P4: inc_pc.
- P5: rd if op_q is ALUOP.
- P6: rd if ALUOP; inc_pc if op_q=SKZ and zero_q=1; ld_pc if JMP; data_e if STO.
- P7: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO.

REQ-007 `zero` SHALL be registered into zero_q at the P5->P6 edge.

REQ-008 In P4 with op_q=HLT, the next state SHALL be HALTED instead of P5. inc_pc SHALL still pulse in that P4 cycle.

REQ-009 In HALTED:
- halt=1 and all other strobes are 0.
- If HALT_RESUME=1 and resume=1, the next state SHALL be P0.
- Otherwise the state SHALL remain HALTED.

REQ-010 `resume` SHALL be ignored in every state other than HALTED.

REQ-011 When run=0, the block SHALL hold its state. Outputs SHALL keep their decoded values, except that wr, ld_ir, ld_ac, inc_pc and ld_pc SHALL be forced to 0, so no side effect repeats.

REQ-012 run=0 together with resume=1 while HALTED SHALL leave the block in HALTED; resume is not latched.

REQ-013 Instruction latency SHALL be exactly 8 enabled cycles, P0 through P7, for every opcode except HLT.

REQ-014 wr and rd SHALL never be asserted in the same cycle.

Reset
REQ-015 Assertion of rst_n=0 SHALL immediately set state to P0, op_q to 000 and zero_q to 0.

REQ-016 During reset, sel=1 and all other outputs SHALL be 0; phase SHALL read 0.

REQ-017 Reset SHALL abort any instruction in progress, including mid-STO. No wr SHALL be asserted after reset is asserted.

REQ-018 The first P0 cycle SHALL follow the first clk rising edge after rst_n deasserts.

Structure
REQ-019 A shared package cpu_pkg SHALL hold the opcode constants, OPW, and the phase/state encoding. The IR and ALU SHALL reuse them.

REQ-020 The output decode SHALL be a combinational sub-module, ctrl_decode, with inputs state, op_q, zero_q and run. The FSM and its registers SHALL live in cpu_sequencer.

Verification
REQ-021 Reset release with run=1 and opcode=010 -> sequence P0..P7; rd high in P1-P3 and P5-P7; ld_ir in P2 only; ld_ac in P7 only; inc_pc in P4 only.

REQ-022 opcode=110 (STO) -> wr=1 and data_e=1 in P7; data_e=1 in P6; rd=0 in P5-P7; no ld_ac.

REQ-023 opcode=001 (SKZ) with zero=1 at P5 -> inc_pc in P4 and P6. Repeat with zero=0 -> inc_pc in P4 only.

REQ-024 opcode=000 (HLT) -> HALTED after P4 and halt=1. Hold 20 cycles with resume=0 -> no change. Pulse resume -> P0 on the next cycle.

REQ-025 opcode=111 (JMP), with run dropped for 3 cycles during P7 -> ld_pc=1 only in enabled cycles of P6 and P7; state frozen while run=0.

REQ-026 rst_n asserted in P7 of STO -> wr drops in the same cycle; after release the sequence restarts at P0 with op_q=000.
